// File: rtl/ts_trigger_ctrl.sv
// ts_trigger_ctrl: trigger sequencing controller.
// Runs the IDLE -> PRE -> WAIT -> POST -> HOLDOFF sequence. It edge-detects
// the trigger sources and produces the capture window, the trigger pulse and
// the end-of-capture pulse for the acquisition datapath.
//
// Control pulses (ctrl_arm, ctrl_abort, ctrl_force) are single-cycle strobes
// with no back-pressure. They are acted on in the cycle they are high and are
// never held or queued; a strobe the current state does not use is dropped.
module ts_trigger_ctrl #(
  parameter int N_SRC     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 ctrl_arm,
  input  logic                 ctrl_abort,
  input  logic                 ctrl_force,
  input  logic [N_SRC-1:0]     cfg_src_mask,
  input  logic [N_SRC-1:0]     cfg_polarity,
  input  logic [CNT_WIDTH-1:0] cfg_pre_cnt,
  input  logic [CNT_WIDTH-1:0] cfg_post_cnt,
  input  logic [CNT_WIDTH-1:0] cfg_holdoff,
  input  logic                 cfg_auto_rearm,
  input  logic [N_SRC-1:0]     trig_in,
  output logic                 capture_en,
  output logic                 trig_out,
  output logic                 done_pulse,
  output logic [2:0]           sts_state,
  output logic [N_SRC-1:0]     sts_trig_src,
  output logic                 sts_forced,
  output logic [15:0]          sts_trig_cnt
);

  // The encoding is visible to software through sts_state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_POST    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // A window of length n is timed by loading n-1 and expiring at zero.
  // A zero length still costs one cycle, so it loads zero as well.
  function automatic logic [CNT_WIDTH-1:0] load_cnt(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? '0 : (len - CNT_ONE);
  endfunction

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Configuration captured at arm; a run never sees later cfg_* changes.
  logic [N_SRC-1:0]     mask_q, mask_d;
  logic [N_SRC-1:0]     pol_q, pol_d;
  logic [CNT_WIDTH-1:0] pre_q, pre_d;
  logic [CNT_WIDTH-1:0] post_q, post_d;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic                 rearm_q, rearm_d;

  logic [N_SRC-1:0]     trig_d_q;

  logic                 capture_q, capture_d;
  logic                 trig_out_q, trig_out_d;
  logic                 done_q, done_d;
  logic [N_SRC-1:0]     src_q, src_d;
  logic                 forced_q, forced_d;
  logic [15:0]          tcnt_q, tcnt_d;

  logic [N_SRC-1:0]     ev;
  logic                 ev_any;

  // Per-source edge events against the previous-cycle sample, using the
  // armed mask and polarity.
  always_comb begin
    ev     = mask_q & ((~pol_q & trig_in & ~trig_d_q) | (pol_q & ~trig_in & trig_d_q));
    ev_any = |ev;
  end

  // Next-state, counter, shadow-config and status logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    pol_d      = pol_q;
    pre_d      = pre_q;
    post_d     = post_q;
    hold_d     = hold_q;
    rearm_d    = rearm_q;
    src_d      = src_q;
    forced_d   = forced_q;
    tcnt_d     = tcnt_q;
    trig_out_d = 1'b0;
    done_d     = 1'b0;

    if (ctrl_abort) begin
      // Abort beats every other event; status is kept for inspection.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_arm) begin
            mask_d   = cfg_src_mask;
            pol_d    = cfg_polarity;
            pre_d    = cfg_pre_cnt;
            post_d   = cfg_post_cnt;
            hold_d   = cfg_holdoff;
            rearm_d  = cfg_auto_rearm;
            src_d    = '0;
            forced_d = 1'b0;
            tcnt_d   = '0;
            state_d  = (cfg_pre_cnt == '0) ? ST_WAIT : ST_PRE;
            cnt_d    = load_cnt(cfg_pre_cnt);
          end
        end

        ST_PRE: begin
          // Source edges are ignored here; only a software force ends PRE early.
          if (ctrl_force) begin
            state_d    = ST_POST;
            cnt_d      = load_cnt(post_q);
            trig_out_d = 1'b1;
            src_d      = '0;
            forced_d   = 1'b1;
            tcnt_d     = tcnt_q + 16'd1;
          end else if (cnt_q == '0) begin
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        ST_WAIT: begin
          // Coincident edges on several sources count as one trigger.
          if (ev_any || ctrl_force) begin
            state_d    = ST_POST;
            cnt_d      = load_cnt(post_q);
            trig_out_d = 1'b1;
            src_d      = ev;
            forced_d   = ctrl_force & ~ev_any;
            tcnt_d     = tcnt_q + 16'd1;
          end
        end

        ST_POST: begin
          if (cnt_q == '0) begin
            state_d = ST_HOLDOFF;
            cnt_d   = load_cnt(hold_q);
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        ST_HOLDOFF: begin
          if (cnt_q == '0) begin
            if (rearm_q) begin
              state_d = (pre_q == '0) ? ST_WAIT : ST_PRE;
              cnt_d   = load_cnt(pre_q);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Registered alongside the state so the window lines up with sts_state.
    capture_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
  end

  // State, counter and shadow configuration registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      pol_q   <= '0;
      pre_q   <= '0;
      post_q  <= '0;
      hold_q  <= '0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      pol_q   <= pol_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      hold_q  <= hold_d;
      rearm_q <= rearm_d;
    end
  end

  // Previous-cycle trigger sample, taken in every state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trig_d_q <= '0;
    end else begin
      trig_d_q <= trig_in;
    end
  end

  // Registered outputs and trigger status.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      capture_q  <= 1'b0;
      trig_out_q <= 1'b0;
      done_q     <= 1'b0;
      src_q      <= '0;
      forced_q   <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      capture_q  <= capture_d;
      trig_out_q <= trig_out_d;
      done_q     <= done_d;
      src_q      <= src_d;
      forced_q   <= forced_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign capture_en   = capture_q;
  assign trig_out     = trig_out_q;
  assign done_pulse   = done_q;
  assign sts_state    = state_q;
  assign sts_trig_src = src_q;
  assign sts_forced   = forced_q;
  assign sts_trig_cnt = tcnt_q;

endmodule

// File: doc/ts_trigger_ctrl.md
Name: ts_trigger_ctrl

Overview:
Trigger sequencing controller for the AXI trigger subsystem. It takes configuration and control pulses from the subsystem's AXI-Lite register file and runs the arm → pre-trigger → wait → post-trigger → holdoff sequence. It edge-detects up to N_SRC trigger sources and generates the capture window and trigger pulse consumed by the acquisition datapath.

Parameters:
N_SRC, 8, number of trigger source inputs
CNT_WIDTH, 16, width of pre/post/holdoff counters and config fields

Ports:
aclk  in  1  single clock for the whole block
aresetn  in  1  reset, asynchronous, active-low
ctrl_arm  in  1  one-cycle pulse: start a sequence (accepted only in IDLE)
ctrl_abort  in  1  one-cycle pulse: return to IDLE from any state
ctrl_force  in  1  one-cycle pulse: software trigger
cfg_src_mask  in  N_SRC  1 = source enabled
cfg_polarity  in  N_SRC  0 = rising edge, 1 = falling edge, per source
cfg_pre_cnt  in  CNT_WIDTH  pre-trigger window length in cycles
cfg_post_cnt  in  CNT_WIDTH  post-trigger window length in cycles
cfg_holdoff  in  CNT_WIDTH  dead time after capture in cycles
cfg_auto_rearm  in  1  1 = re-enter PRE after HOLDOFF, 0 = go to IDLE
trig_in  in  N_SRC  trigger sources, already synchronous to aclk
capture_en  out  1  acquisition window active
trig_out  out  1  one-cycle pulse on accepted trigger
done_pulse  out  1  one-cycle pulse when POST completes
sts_state  out  3  current state encoding
sts_trig_src  out  N_SRC  event vector latched at the last trigger
sts_forced  out  1  last trigger was ctrl_force
sts_trig_cnt  out  16  number of accepted triggers since last arm

Behaviour:
- Reset (async, aresetn=0): state IDLE; all outputs 0; counters, shadow config and trig_d cleared.
- States and encoding: IDLE=0, PRE=1, WAIT=2, POST=3, HOLDOFF=4. sts_state is a direct register output.
- Arm (IDLE and ctrl_arm):
  - Latch cfg_* into shadow registers; config changes during a run have no effect until the next arm.
  - Clear sts_trig_cnt, sts_trig_src and sts_forced.
  - Next state is PRE, or WAIT if shadow pre_cnt = 0.
- ctrl_arm outside IDLE is ignored.
- PRE: stays exactly pre_cnt cycles, then moves to WAIT. Source events are ignored in PRE.
- Edge detect:
  - trig_d <= trig_in every cycle.
  - ev = mask & ((~pol & trig_in & ~trig_d) | (pol & ~trig_in & trig_d)).
  - Events are evaluated only in WAIT.
- WAIT to POST on cycle k when |ev or ctrl_force:
  - State is POST at k+1.
  - trig_out = 1 during cycle k+1 only.
  - sts_trig_src <= ev; sts_forced <= ctrl_force & ~|ev.
  - sts_trig_cnt increments and wraps at 16 bits.
  - Simultaneous source events on multiple sources are all recorded in sts_trig_src and count as one trigger.
- ctrl_force in PRE: accepted as a trigger with the same update rules as WAIT; the remaining pre window is skipped.
- POST: stays post_cnt cycles, then done_pulse = 1 for one cycle and the state moves to HOLDOFF. If post_cnt = 0, the state goes WAIT → POST (1 cycle) → HOLDOFF, i.e. POST always occupies at least the trig_out cycle.
- HOLDOFF: stays holdoff cycles (0 = a single pass-through cycle), then goes to PRE/WAIT (same rule as arm) if auto_rearm, else IDLE.
- capture_en = 1 exactly when state ∈ {PRE, WAIT, POST}; it is registered and aligned with sts_state.
- Abort: from any state, the next state is IDLE.
  - Abort has priority over trigger, force, arm and counter expiry in the same cycle.
  - No done_pulse; sts_trig_src, sts_forced and sts_trig_cnt are retained.
- Counters use CNT_WIDTH bits and load (value−1) on state entry; maximum window = 2^CNT_WIDTH−1 cycles.

Test Plan:
- Reset mid-run: arm, then assert aresetn=0 in POST → capture_en=0, sts_state=0 immediately (async); after release, the block stays IDLE.
- Arm with pre=4, post=3, holdoff=2, mask=0x01, pol=0; rising trig_in[0] 2 cycles after WAIT entry:
  - capture_en high for 4+2+1+3 cycles.
  - trig_out one cycle after the edge.
  - done_pulse after 3 POST cycles; sts_trig_src=0x01; sts_trig_cnt=1; IDLE after 2 holdoff cycles.
- Edge in PRE: mask=0x03, pol=0x02, trig_in[0] rising and trig_in[1] falling during PRE → no trigger; the same pattern in WAIT, on the same cycle → one trigger, sts_trig_src=0x03, sts_trig_cnt=1.
- pre=0, post=0, holdoff=0, auto_rearm=1, ctrl_force in WAIT:
  - State sequence is WAIT → POST (1 cycle) → HOLDOFF (1 cycle) → WAIT.
  - sts_forced=1, sts_trig_src=0; repeating 3 forces → sts_trig_cnt=3.
- ctrl_abort on the same cycle as a trig_in edge in WAIT → IDLE next cycle, trig_out=0, done_pulse=0, sts_trig_cnt unchanged.
- Change cfg_post_cnt from 3 to 10 while in WAIT → the current run still uses POST=3 cycles; a second arm uses 10.
